// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte-write master among NUM_REQ sequencers.
// A grant covers a whole sequence; a watchdog can force a hung owner off the bus.
module spi_bus_arbiter #(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned CTRL_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned GAP_CYC  = 4,
   parameter int unsigned HOLD_MAX = 0
) (
   input  logic                        sys_clk_i,
   input  logic                        rst_i,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ-1:0]          start_i,
   input  logic [NUM_REQ*CTRL_W-1:0]   ctrl_i,
   input  logic [NUM_REQ*DATA_W-1:0]   data_i,
   output logic [NUM_REQ-1:0]          busy_o,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic                        spi_start_o,
   output logic [CTRL_W-1:0]           spi_ctrl_o,
   output logic [DATA_W-1:0]           spi_data_o,
   input  logic                        spi_busy_i,
   output logic                        drop_o,
   output logic                        timeout_o
);

   localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
   localparam int unsigned GAP_W     = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
   localparam int unsigned HOLD_W    = 24;
   localparam int unsigned HOLD_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_GAP} state_e;

   state_e              state_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    owner_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic                spi_start_q;
   logic [CTRL_W-1:0]   spi_ctrl_q;
   logic [DATA_W-1:0]   spi_data_q;
   logic                drop_q;
   logic                timeout_q;
   logic [GAP_W-1:0]    gap_cnt_q;
   logic [HOLD_W-1:0]   hold_cnt_q;

   logic                found_d;
   logic [IDX_W-1:0]    sel_d;
   logic [IDX_W-1:0]    cand_d;
   logic                own_req_d;
   logic                own_start_d;
   logic [CTRL_W-1:0]   own_ctrl_d;
   logic [DATA_W-1:0]   own_data_d;
   logic                fwd_d;
   logic                drop_d;

   // First requester at or above the pointer, wrapping around.
   always_comb begin
      found_d = 1'b0;
      sel_d   = '0;
      cand_d  = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         cand_d = IDX_W'((int'(ptr_q) + k) % int'(NUM_REQ));
         for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found_d && (cand_d == IDX_W'(j)) && req_i[j]) begin
               found_d = 1'b1;
               sel_d   = cand_d;
            end
         end
      end
   end

   // Owner's request lines and payload slices.
   always_comb begin
      own_req_d   = 1'b0;
      own_start_d = 1'b0;
      own_ctrl_d  = '0;
      own_data_d  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_req_d   = req_i[i];
            own_start_d = start_i[i];
            own_ctrl_d  = ctrl_i[i*CTRL_W +: CTRL_W];
            own_data_d  = data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   // Any start that is not forwarded this cycle is reported as dropped.
   assign fwd_d  = (state_q == S_GRANT) && own_start_d && !spi_busy_i && !spi_start_q;
   assign drop_d = |(start_i & ~(fwd_d ? gnt_q : '0));

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         gnt_q       <= '0;
         spi_start_q <= 1'b0;
         spi_ctrl_q  <= '0;
         spi_data_q  <= '0;
         drop_q      <= 1'b0;
         timeout_q   <= 1'b0;
         gap_cnt_q   <= '0;
         hold_cnt_q  <= '0;
      end else begin
         spi_start_q <= fwd_d;
         drop_q      <= drop_d;
         timeout_q   <= 1'b0;
         if (fwd_d) begin
            spi_ctrl_q <= own_ctrl_d;
            spi_data_q <= own_data_d;
         end
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  gnt_q      <= NUM_REQ'(1) << sel_d;
                  owner_q    <= sel_d;
                  hold_cnt_q <= '0;
                  state_q    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (!own_req_d) begin
                  state_q <= S_DRAIN;
               end else if (HOLD_MAX > 0) begin
                  if (hold_cnt_q == HOLD_W'(HOLD_LAST)) begin
                     timeout_q <= 1'b1;
                     state_q   <= S_DRAIN;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Release only once the last forwarded byte has left the master.
               if (!spi_busy_i && !spi_start_q) begin
                  gnt_q     <= '0;
                  ptr_q     <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                  gap_cnt_q <= '0;
                  state_q   <= (GAP_CYC > 0) ? S_GAP : S_IDLE;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Non-owners always see busy; the owner sees the master plus a pending start.
   assign busy_o      = ~gnt_q | {NUM_REQ{spi_busy_i | spi_start_q}};
   assign gnt_o       = gnt_q;
   assign spi_start_o = spi_start_q;
   assign spi_ctrl_o  = spi_ctrl_q;
   assign spi_data_o  = spi_data_q;
   assign drop_o      = drop_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: per-cycle vector table plus hand sequences
// for gap timing, watchdog release and asynchronous reset.
module tb_spi_bus_arbiter;

   logic        sys_clk_i;
   logic        rst_i;
   logic [1:0]  req_i;
   logic [1:0]  start_i;
   logic [31:0] ctrl_i;
   logic [15:0] data_i;
   logic [1:0]  busy_o;
   logic [1:0]  gnt_o;
   logic        spi_start_o;
   logic [15:0] spi_ctrl_o;
   logic [7:0]  spi_data_o;
   logic        spi_busy_i;
   logic        drop_o;
   logic        timeout_o;

   int checks = 0;
   int errors = 0;

   spi_bus_arbiter #(
      .NUM_REQ (2),
      .CTRL_W  (16),
      .DATA_W  (8),
      .GAP_CYC (4),
      .HOLD_MAX(100)
   ) dut (
      .sys_clk_i  (sys_clk_i),
      .rst_i      (rst_i),
      .req_i      (req_i),
      .start_i    (start_i),
      .ctrl_i     (ctrl_i),
      .data_i     (data_i),
      .busy_o     (busy_o),
      .gnt_o      (gnt_o),
      .spi_start_o(spi_start_o),
      .spi_ctrl_o (spi_ctrl_o),
      .spi_data_o (spi_data_o),
      .spi_busy_i (spi_busy_i),
      .drop_o     (drop_o),
      .timeout_o  (timeout_o)
   );

   initial sys_clk_i = 1'b0;
   always #5 sys_clk_i = ~sys_clk_i;

   typedef struct packed {
      logic [1:0]  req;
      logic [1:0]  start;
      logic [31:0] ctrl;
      logic [15:0] data;
      logic        busy;
      logic [1:0]  e_gnt;
      logic [1:0]  e_busy;
      logic        e_start;
      logic [15:0] e_ctrl;
      logic [7:0]  e_data;
      logic        e_drop;
      logic        e_to;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i      = 1'b1;
      req_i      = '0;
      start_i    = '0;
      ctrl_i     = '0;
      data_i     = '0;
      spi_busy_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"},   32'(gnt_o),       32'h0);
      chk({tag, "_busy"},  32'(busy_o),      32'h3);
      chk({tag, "_start"}, 32'(spi_start_o), 32'h0);
      chk({tag, "_ctrl"},  32'(spi_ctrl_o),  32'h0);
      chk({tag, "_data"},  32'(spi_data_o),  32'h0);
      chk({tag, "_drop"},  32'(drop_o),      32'h0);
      chk({tag, "_to"},    32'(timeout_o),   32'h0);
   endtask

   initial begin
      int n;
      vec_t v;

      //        req    start  ctrl{1,0}      data{1,0} busy  gnt    busy_o st  ctrl      data   drop  to
      vq.push_back('{2'b01, 2'b00, 32'hBBBB_0000, 16'h7718, 1'b0, 2'b01, 2'b10, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0});
      vq.push_back('{2'b01, 2'b01, 32'hBBBB_0000, 16'h7718, 1'b0, 2'b01, 2'b11, 1'b1, 16'h0000, 8'h18, 1'b0, 1'b0});
      vq.push_back('{2'b01, 2'b00, 32'hBBBB_0000, 16'h7718, 1'b1, 2'b01, 2'b11, 1'b0, 16'h0000, 8'h18, 1'b0, 1'b0});
      vq.push_back('{2'b01, 2'b01, 32'hBBBB_1234, 16'h7755, 1'b1, 2'b01, 2'b11, 1'b0, 16'h0000, 8'h18, 1'b1, 1'b0});
      vq.push_back('{2'b01, 2'b00, 32'hBBBB_1234, 16'h7755, 1'b0, 2'b01, 2'b10, 1'b0, 16'h0000, 8'h18, 1'b0, 1'b0});
      vq.push_back('{2'b01, 2'b01, 32'hBBBB_1234, 16'h7755, 1'b0, 2'b01, 2'b11, 1'b1, 16'h1234, 8'h55, 1'b0, 1'b0});
      vq.push_back('{2'b01, 2'b10, 32'hBBBB_1234, 16'h7755, 1'b0, 2'b01, 2'b10, 1'b0, 16'h1234, 8'h55, 1'b1, 1'b0});
      vq.push_back('{2'b01, 2'b01, 32'hBBBB_A5A5, 16'h773C, 1'b0, 2'b01, 2'b11, 1'b1, 16'hA5A5, 8'h3C, 1'b0, 1'b0});
      vq.push_back('{2'b01, 2'b01, 32'hBBBB_0F0F, 16'h77C3, 1'b0, 2'b01, 2'b10, 1'b0, 16'hA5A5, 8'h3C, 1'b1, 1'b0});
      vq.push_back('{2'b00, 2'b01, 32'hBBBB_0F0F, 16'h77C3, 1'b0, 2'b01, 2'b11, 1'b1, 16'h0F0F, 8'hC3, 1'b0, 1'b0});
      vq.push_back('{2'b00, 2'b01, 32'hBBBB_0F0F, 16'h77C3, 1'b1, 2'b01, 2'b11, 1'b0, 16'h0F0F, 8'hC3, 1'b1, 1'b0});
      vq.push_back('{2'b00, 2'b00, 32'hBBBB_0F0F, 16'h77C3, 1'b0, 2'b00, 2'b11, 1'b0, 16'h0F0F, 8'hC3, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++)
         vq.push_back('{2'b10, 2'b00, 32'hBEEF_0F0F, 16'h42C3, 1'b0, 2'b00, 2'b11, 1'b0, 16'h0F0F, 8'hC3, 1'b0, 1'b0});
      vq.push_back('{2'b10, 2'b00, 32'hBEEF_0F0F, 16'h42C3, 1'b0, 2'b10, 2'b01, 1'b0, 16'h0F0F, 8'hC3, 1'b0, 1'b0});
      vq.push_back('{2'b10, 2'b10, 32'hBEEF_0F0F, 16'h42C3, 1'b0, 2'b10, 2'b11, 1'b1, 16'hBEEF, 8'h42, 1'b0, 1'b0});
      vq.push_back('{2'b00, 2'b00, 32'hBEEF_0F0F, 16'h42C3, 1'b0, 2'b10, 2'b01, 1'b0, 16'hBEEF, 8'h42, 1'b0, 1'b0});
      vq.push_back('{2'b00, 2'b00, 32'hBEEF_0F0F, 16'h42C3, 1'b0, 2'b00, 2'b11, 1'b0, 16'hBEEF, 8'h42, 1'b0, 1'b0});
      vq.push_back('{2'b00, 2'b01, 32'hBEEF_0F0F, 16'h42C3, 1'b0, 2'b00, 2'b11, 1'b0, 16'hBEEF, 8'h42, 1'b1, 1'b0});

      // Reset values, then the per-cycle table.
      do_reset();
      chk_reset_vals("rst");
      for (int i = 0; i < vq.size(); i++) begin
         v          = vq[i];
         req_i      = v.req;
         start_i    = v.start;
         ctrl_i     = v.ctrl;
         data_i     = v.data;
         spi_busy_i = v.busy;
         tick();
         chk($sformatf("v%0d_gnt", i),   32'(gnt_o),       32'(v.e_gnt));
         chk($sformatf("v%0d_busy", i),  32'(busy_o),      32'(v.e_busy));
         chk($sformatf("v%0d_start", i), 32'(spi_start_o), 32'(v.e_start));
         chk($sformatf("v%0d_ctrl", i),  32'(spi_ctrl_o),  32'(v.e_ctrl));
         chk($sformatf("v%0d_data", i),  32'(spi_data_o),  32'(v.e_data));
         chk($sformatf("v%0d_drop", i),  32'(drop_o),      32'(v.e_drop));
         chk($sformatf("v%0d_to", i),    32'(timeout_o),   32'(v.e_to));
      end

      // Both request from reset: 0 first, then 1 after drain plus 4-cycle gap.
      do_reset();
      req_i = 2'b11;
      tick();
      chk("rr_first", 32'(gnt_o), 32'h1);
      tick();
      req_i = 2'b10;
      tick();
      chk("rr_drain_hold", 32'(gnt_o), 32'h1);
      tick();
      chk("rr_release", 32'(gnt_o), 32'h0);
      n = 0;
      while (gnt_o == 2'b00 && n < 50) begin
         tick();
         n++;
      end
      chk("rr_gap_edges", 32'(n), 32'd5);
      chk("rr_second", 32'(gnt_o), 32'h2);

      // Watchdog: owner 0 never drops its request.
      do_reset();
      req_i = 2'b11;
      tick();
      chk("wd_grant", 32'(gnt_o), 32'h1);
      n = 0;
      while (timeout_o !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("wd_timeout_cycle", 32'(n), 32'd100);
      chk("wd_gnt_at_timeout", 32'(gnt_o), 32'h1);
      tick();
      chk("wd_pulse_width", 32'(timeout_o), 32'h0);
      chk("wd_release", 32'(gnt_o), 32'h0);
      n = 0;
      while (gnt_o == 2'b00 && n < 50) begin
         tick();
         n++;
      end
      chk("wd_gap_edges", 32'(n), 32'd5);
      chk("wd_regrant", 32'(gnt_o), 32'h2);

      // Async reset mid-grant while a start is in flight; pointer must return to 0.
      do_reset();
      req_i = 2'b01;
      tick();
      req_i = 2'b00;
      tick();
      tick();
      chk("ar_first_release", 32'(gnt_o), 32'h0);
      req_i = 2'b10;
      n = 0;
      while (gnt_o != 2'b10 && n < 50) begin
         tick();
         n++;
      end
      chk("ar_owner1", 32'(gnt_o), 32'h2);
      start_i = 2'b10;
      ctrl_i  = 32'hCAFE_0000;
      data_i  = 16'h9900;
      tick();
      start_i = 2'b00;
      chk("ar_start_high", 32'(spi_start_o), 32'h1);
      chk("ar_ctrl", 32'(spi_ctrl_o), 32'hCAFE);
      #2;
      rst_i = 1'b1;
      #1;
      chk_reset_vals("ar");
      tick();
      #2;
      rst_i = 1'b0;
      req_i = 2'b11;
      tick();
      chk("ar_regrant_ptr0", 32'(gnt_o), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
